// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RV32I execute-stage ALU.
//   - combinational decoder: opcode/funct3/instr[30] -> 4-bit ALU operation
//   - combinational 32-bit ALU (Out), plus a registered copy (Out_r)
// Optional feature macro: ALU_ILLEGAL_EN
//   When defined, adds Illegal (combinational, high on unsupported opcode)
//   and Illegal_r (registered alongside Out_r, resets to 0).
module alu_exec_unit #(
   parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct,
   input  logic        add_rshift_type,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [3:0]  ALUop,
   output logic [31:0] Out,
   output logic [31:0] Out_r
`ifdef ALU_ILLEGAL_EN
   ,
   output logic        Illegal,
   output logic        Illegal_r
`endif
);

   // ALU operation encoding
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_COPYB = 4'd10;
   localparam logic [3:0] ALU_XXX   = 4'd15;

   // RV32I major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_ARI    = 7'b0110011;
   localparam logic [6:0] OPC_ARII   = 7'b0010011;

   logic [4:0]  shamt;
   logic [31:0] out_r_d, out_r_q;

   assign shamt = B[4:0];

   // Decode opcode/funct3/instr[30]; default to unsupported so every path is defined
   always_comb begin
      ALUop = ALU_XXX;
      case (opcode)
         OPC_LUI:    ALUop = ALU_COPYB;
         OPC_AUIPC,
         OPC_JAL,
         OPC_JALR,
         OPC_BRANCH,
         OPC_LOAD,
         OPC_STORE:  ALUop = ALU_ADD;
         OPC_ARI,
         OPC_ARII: begin
            case (funct)
               // ADDI has no SUB form: bit 30 belongs to the immediate there
               3'b000:  ALUop = (add_rshift_type && (opcode == OPC_ARI)) ? ALU_SUB : ALU_ADD;
               3'b001:  ALUop = ALU_SLL;
               3'b010:  ALUop = ALU_SLT;
               3'b011:  ALUop = ALU_SLTU;
               3'b100:  ALUop = ALU_XOR;
               3'b101:  ALUop = add_rshift_type ? ALU_SRA : ALU_SRL;
               3'b110:  ALUop = ALU_OR;
               default: ALUop = ALU_AND;
            endcase
         end
         default:    ALUop = ALU_XXX;
      endcase
   end

   // 32-bit datapath; unsupported operations produce zero
   always_comb begin
      Out = 32'h0;
      case (ALUop)
         ALU_ADD:   Out = A + B;
         ALU_SUB:   Out = A - B;
         ALU_AND:   Out = A & B;
         ALU_OR:    Out = A | B;
         ALU_XOR:   Out = A ^ B;
         ALU_SLT:   Out = {31'b0, ($signed(A) < $signed(B))};
         ALU_SLTU:  Out = {31'b0, (A < B)};
         ALU_SLL:   Out = A << shamt;
         ALU_SRL:   Out = A >> shamt;
         ALU_SRA:   Out = $unsigned($signed(A) >>> shamt);
         ALU_COPYB: Out = B;
         default:   Out = 32'h0;
      endcase
   end

   // Next-state of the pipeline register is simply the current result
   always_comb begin
      out_r_d = Out;
   end

   // Pipeline register for the result, asynchronously cleared
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) out_r_q <= OUT_RESET;
      else          out_r_q <= out_r_d;
   end

   assign Out_r = out_r_q;

`ifdef ALU_ILLEGAL_EN
   logic illegal_r_d, illegal_r_q;

   assign Illegal = (ALUop == ALU_XXX);

   // Next-state of the illegal flag register
   always_comb begin
      illegal_r_d = Illegal;
   end

   // Illegal flag travels with the registered result
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) illegal_r_q <= 1'b0;
      else          illegal_r_q <= illegal_r_d;
   end

   assign Illegal_r = illegal_r_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: vector table, reset sequences and random stimulus against
// an arithmetic reference model of alu_exec_unit.
module tb_alu_exec_unit;

   logic        Clock = 1'b0;
   logic        Reset_n;
   logic [6:0]  opcode;
   logic [2:0]  funct;
   logic        add_rshift_type;
   logic [31:0] A, B;
   logic [3:0]  ALUop;
   logic [31:0] Out, Out_r;
`ifdef ALU_ILLEGAL_EN
   logic        Illegal, Illegal_r;
`endif

   int tests = 0;
   int fails = 0;

   alu_exec_unit dut (
      .Clock(Clock),
      .Reset_n(Reset_n),
      .opcode(opcode),
      .funct(funct),
      .add_rshift_type(add_rshift_type),
      .A(A),
      .B(B),
      .ALUop(ALUop),
      .Out(Out),
      .Out_r(Out_r)
`ifdef ALU_ILLEGAL_EN
      ,
      .Illegal(Illegal),
      .Illegal_r(Illegal_r)
`endif
   );

   always #5 Clock = ~Clock;

   typedef struct {
      logic [6:0]  opc;
      logic [2:0]  f;
      logic        art;
      bit          rnd;      // randomize funct/add_rshift_type
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  exp_op;
      logic [31:0] exp_out;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [3:0] m_op(input logic [6:0] opc, input logic [2:0] f, input logic art);
      int rtab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
      logic [6:0] add_opcs [6] = '{7'b0010111, 7'b1101111, 7'b1100111,
                                   7'b1100011, 7'b0000011, 7'b0100011};
      if (opc == 7'b0110111) return 4'd10;
      foreach (add_opcs[i]) if (opc == add_opcs[i]) return 4'd0;
      if (opc == 7'b0110011 || opc == 7'b0010011) begin
         if (f == 3'd0) return (opc == 7'b0110011 && art) ? 4'd1 : 4'd0;
         if (f == 3'd5) return art ? 4'd9 : 4'd8;
         return 4'(rtab[f]);
      end
      return 4'd15;
   endfunction

   function automatic longint as_signed(input logic [31:0] v);
      return (v >= 32'h8000_0000) ? longint'(v) - 64'sh1_0000_0000 : longint'(v);
   endfunction

   function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      longint ua = longint'(a);
      longint ub = longint'(b);
      longint sa = as_signed(a);
      longint sb = as_signed(b);
      longint p  = longint'(1) << b[4:0];
      longint m  = 64'sh1_0000_0000;
      longint r;
      case (op)
         4'd0:  r = (ua + ub) % m;
         4'd1:  r = (ua - ub + m) % m;
         4'd2:  r = longint'(a & b);
         4'd3:  r = longint'(a | b);
         4'd4:  r = longint'(a ^ b);
         4'd5:  r = (sa < sb) ? 1 : 0;
         4'd6:  r = (ua < ub) ? 1 : 0;
         4'd7:  r = (ua * p) % m;
         4'd8:  r = ua / p;
         4'd9:  r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);  // floor division
         4'd10: r = ub;
         default: r = 0;
      endcase
      return 32'(r);
   endfunction

   // ---------------- stimulus ----------------
   vec_t vecs [18];
   logic [6:0] legal [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011};

   initial begin
      logic [3:0]  eop;
      logic [31:0] eout;

      vecs[0]  = '{7'b0110111, 3'd0, 1'b0, 1, 32'h8000_1234, 32'hFFFF_8123, 4'd10, 32'hFFFF_8123};
      vecs[1]  = '{7'b0010111, 3'd0, 1'b0, 1, 32'h8000_0001, 32'hFFFF_8001, 4'd0,  32'h7FFF_8002};
      vecs[2]  = '{7'b1100011, 3'd0, 1'b0, 1, 32'h8000_0001, 32'hFFFF_8001, 4'd0,  32'h7FFF_8002};
      vecs[3]  = '{7'b0000011, 3'd0, 1'b0, 1, 32'h8000_0001, 32'hFFFF_8001, 4'd0,  32'h7FFF_8002};
      vecs[4]  = '{7'b0100011, 3'd0, 1'b0, 1, 32'h8000_0001, 32'hFFFF_8001, 4'd0,  32'h7FFF_8002};
      vecs[5]  = '{7'b1101111, 3'd0, 1'b0, 1, 32'h8000_0001, 32'hFFFF_8001, 4'd0,  32'h7FFF_8002};
      vecs[6]  = '{7'b0110011, 3'd0, 1'b1, 0, 32'd5, 32'd7, 4'd1, 32'hFFFF_FFFE};
      vecs[7]  = '{7'b0110011, 3'd0, 1'b0, 0, 32'd5, 32'd7, 4'd0, 32'h0000_000C};
      vecs[8]  = '{7'b0010011, 3'd0, 1'b1, 0, 32'd5, 32'd7, 4'd0, 32'h0000_000C};
      vecs[9]  = '{7'b0110011, 3'd5, 1'b1, 0, 32'h8000_0000, 32'hFFFF_FFE4, 4'd9, 32'hF800_0000};
      vecs[10] = '{7'b0110011, 3'd5, 1'b0, 0, 32'h8000_0000, 32'hFFFF_FFE4, 4'd8, 32'h0800_0000};
      vecs[11] = '{7'b0110011, 3'd2, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'h0000_0001};
      vecs[12] = '{7'b0110011, 3'd3, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'h0000_0000};
      vecs[13] = '{7'b0110011, 3'd7, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 4'd2, 32'h0000_0001};
      vecs[14] = '{7'b0110011, 3'd6, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'hFFFF_FFFF};
      vecs[15] = '{7'b0110011, 3'd4, 1'b0, 0, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'hFFFF_FFFE};
      vecs[16] = '{7'b0010011, 3'd1, 1'b1, 0, 32'h0000_0001, 32'hFFFF_FFFF, 4'd7, 32'h8000_0000};
      vecs[17] = '{7'b1111111, 3'd0, 1'b0, 1, 32'hDEAD_BEEF, 32'h1234_5678, 4'd15, 32'h0000_0000};

      // ---- reset state; combinational path must work while in reset ----
      Reset_n = 1'b0;
      opcode = 7'b0110111; funct = 3'd3; add_rshift_type = 1'b1;
      A = 32'h0; B = 32'hCAFE_F00D;
      #2;
      chk("reset_out_r", Out_r, 32'h0);
      chk("reset_comb_out", Out, 32'hCAFE_F00D);
      chk("reset_comb_op", {28'h0, ALUop}, 32'd10);
      @(posedge Clock); #1;
      chk("reset_hold_edge", Out_r, 32'h0);
`ifdef ALU_ILLEGAL_EN
      chk("reset_illegal_r", {31'h0, Illegal_r}, 32'h0);
`endif
      // release mid-cycle: must hold reset value until the next rising edge
      #2 Reset_n = 1'b1;
      #1 chk("release_hold", Out_r, 32'h0);
      @(posedge Clock); #1;
      chk("release_capture", Out_r, 32'hCAFE_F00D);

      // ---- directed vector table ----
      foreach (vecs[i]) begin
         @(negedge Clock);
         opcode = vecs[i].opc;
         funct  = vecs[i].rnd ? 3'($urandom_range(7)) : vecs[i].f;
         add_rshift_type = vecs[i].rnd ? 1'($urandom_range(1)) : vecs[i].art;
         A = vecs[i].a; B = vecs[i].b;
         #1;
         $display("vec %0d: opc=%b f=%0d art=%0d A=%08h B=%08h -> op=%0d out=%08h",
                  i, opcode, funct, add_rshift_type, A, B, ALUop, Out);
         chk($sformatf("vec%0d_op", i), {28'h0, ALUop}, {28'h0, vecs[i].exp_op});
         chk($sformatf("vec%0d_out", i), Out, vecs[i].exp_out);
`ifdef ALU_ILLEGAL_EN
         chk($sformatf("vec%0d_illegal", i), {31'h0, Illegal}, {31'h0, vecs[i].exp_op == 4'd15});
`endif
         @(posedge Clock); #1;
         chk($sformatf("vec%0d_out_r", i), Out_r, vecs[i].exp_out);
`ifdef ALU_ILLEGAL_EN
         chk($sformatf("vec%0d_illegal_r", i), {31'h0, Illegal_r}, {31'h0, vecs[i].exp_op == 4'd15});
`endif
      end

      // ---- asynchronous reset between edges ----
      @(negedge Clock);
      opcode = 7'b0110111; B = 32'h1234_5678; A = 32'h0;
      @(posedge Clock); #1;
      chk("async_pre", Out_r, 32'h1234_5678);
      #2 Reset_n = 1'b0;
      #1;
      $display("async reset asserted mid-cycle: Out_r=%08h", Out_r);
      chk("async_clear", Out_r, 32'h0);
      chk("async_comb", Out, 32'h1234_5678);
      @(posedge Clock); #1;
      chk("async_hold", Out_r, 32'h0);
      @(negedge Clock);
      Reset_n = 1'b1;
      #1 chk("async_release_hold", Out_r, 32'h0);
      @(posedge Clock); #1;
      chk("async_recapture", Out_r, 32'h1234_5678);

      // ---- randomized stimulus against the reference model ----
      for (int n = 0; n < 300; n++) begin
         @(negedge Clock);
         opcode = ($urandom_range(3) == 0) ? 7'($urandom) : legal[$urandom_range(8)];
         funct  = 3'($urandom);
         add_rshift_type = 1'($urandom);
         case ($urandom_range(3))
            0: begin A = 32'h8000_0000; B = 32'($urandom); end
            1: begin A = 32'($urandom); B = 32'hFFFF_FFFF; end
            default: begin A = 32'($urandom); B = 32'($urandom); end
         endcase
         eop  = m_op(opcode, funct, add_rshift_type);
         eout = m_alu(eop, A, B);
         #1;
         $display("rnd %0d: opc=%b f=%0d art=%0d A=%08h B=%08h -> op=%0d out=%08h (exp %0d %08h)",
                  n, opcode, funct, add_rshift_type, A, B, ALUop, Out, eop, eout);
         chk("rnd_op", {28'h0, ALUop}, {28'h0, eop});
         chk("rnd_out", Out, eout);
`ifdef ALU_ILLEGAL_EN
         chk("rnd_illegal", {31'h0, Illegal}, {31'h0, eop == 4'd15});
`endif
         @(posedge Clock); #1;
         chk("rnd_out_r", Out_r, eout);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- RV32I execute-stage arithmetic block for the MIPS150-class processor.
- Contains two parts:
  - a combinational decoder that maps opcode/funct3/instr[30] to a 4-bit ALU operation;
  - a 32-bit combinational ALU.
- Also provides a registered copy of the result for the next pipeline stage.
- Sits between operand muxing (A/B selection) and the memory/writeback stage.

Parameters:
- OUT_RESET, 32'h0000_0000, value loaded into Out_r on reset.

Ports:
- Clock  in  1  pipeline clock; Out_r updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0].
- funct  in  3  instr[14:12].
- add_rshift_type  in  1  instr[30]; selects SUB vs ADD and SRA vs SRL.
- A  in  32  operand A (rs1 or PC).
- B  in  32  operand B (rs2 or sign-extended/shifted immediate).
- ALUop  out  4  decoded operation, combinational.
- Out  out  32  ALU result, combinational, zero latency.
- Out_r  out  32  Out registered, 1-cycle latency.

Behaviour:
- ALUop encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 COPY_B.
  - 15 XXX (unsupported).
- Decode, opcode-driven; funct and add_rshift_type are ignored unless stated:
  - LUI 0110111 -> COPY_B.
  - AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011 -> ADD.
  - R-type 0110011 by funct:
    - 000 -> SUB if add_rshift_type, else ADD.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - 101 -> SRA if add_rshift_type, else SRL.
    - 110 OR, 111 AND.
  - I-type 0010011: same as R-type except funct 000 is always ADD, since ADDI ignores bit 30.
  - Any other opcode -> XXX.
- ALU:
  - ADD/SUB: modulo 2^32, no carry or overflow output.
  - SLT: signed compare, result 32'h1 or 32'h0.
  - SLTU: unsigned compare, result 32'h1 or 32'h0.
  - Shifts: amount B[4:0]; B[31:5] ignored. SRA replicates A[31].
  - COPY_B: Out = B.
  - XXX: Out = 32'h0.
- Out, ALUop: purely combinational. They must be settled within the same cycle as the inputs change; no internal state.
- Out_r:
  - Captures Out on every rising Clock while Reset_n is high.
  - Reset_n low forces Out_r = OUT_RESET immediately, independent of Clock.
  - Reset released mid-cycle: Out_r holds OUT_RESET until the next rising edge.
- Combinational outputs are unaffected by reset.
- No X propagation for defined opcodes, for any values of funct or add_rshift_type.

Optional Feature:
- Macro: ALU_ILLEGAL_EN.
- Defined:
  - Adds output Illegal (1 bit, combinational). Illegal = 1 when the decoder produces XXX.
  - Adds Illegal_r, registered alongside Out_r with reset value 0.
- Undefined:
  - Neither port exists.
  - Unsupported opcodes still give ALUop = 15 and Out = 0.

Test Plan:
- LUI, A=0x80001234, B=0xFFFF8123, random funct and add_rshift_type -> Out=0xFFFF8123; Out_r equals it after the next rising edge.
- AUIPC/BRANCH/LOAD/STORE, A=0x80000001, B=0xFFFF8001, random funct and add_rshift_type -> Out=0x7FFF8002 (ADD, wrap).
- R-type: A=5, B=7, funct 000:
  - add_rshift_type=1 -> 0xFFFFFFFE.
  - add_rshift_type=0 -> 0x0000000C.
  - I-type with add_rshift_type=1 -> 0x0000000C.
- funct 101, A=0x80000000, B=0xFFFFFFE4 (shift amount 4):
  - add_rshift_type=1 -> 0xF8000000.
  - add_rshift_type=0 -> 0x08000000.
- A=0xFFFFFFFF, B=1:
  - SLT -> 1; SLTU -> 0.
  - AND -> 1; OR -> 0xFFFFFFFF; XOR -> 0xFFFFFFFE.
- Reset: Out_r=0x12345678, assert Reset_n=0 between edges -> Out_r=0 immediately. Opcode 1111111 -> ALUop=15, Out=0 (Illegal=1 when ALU_ILLEGAL_EN).
